// File: rtl/rv_branch_predictor_pkg.sv
// Shared definitions for the fetch-side branch predictor: 2-bit counter
// encodings plus the reset and allocation values used by the table.
package rv_branch_predictor_pkg;

    typedef logic [1:0] bht_ctr_t;

    localparam bht_ctr_t BHT_SNT = 2'b00;  // strongly not taken
    localparam bht_ctr_t BHT_WNT = 2'b01;  // weakly not taken
    localparam bht_ctr_t BHT_WT  = 2'b10;  // weakly taken
    localparam bht_ctr_t BHT_ST  = 2'b11;  // strongly taken

    // Counter value after reset, and value written when a taken branch allocates.
    localparam bht_ctr_t BHT_RST   = BHT_WNT;
    localparam bht_ctr_t BHT_ALLOC = BHT_WT;

    localparam int PC_W = 64;

endpackage

// File: rtl/rv_bht_counter.sv
// Combinational next-state function of a 2-bit saturating branch counter.
module rv_bht_counter
    import rv_branch_predictor_pkg::*;
(
    input  bht_ctr_t ctr_i,
    input  logic     taken_i,
    output bht_ctr_t ctr_o
);

    // Step towards taken or not-taken, holding at the end values.
    always_comb begin
        ctr_o = ctr_i;
        if (taken_i) begin
            if (ctr_i != BHT_ST) ctr_o = ctr_i + 2'd1;
        end else begin
            if (ctr_i != BHT_SNT) ctr_o = ctr_i - 2'd1;
        end
    end

endmodule

// File: rtl/rv_branch_predictor.sv
// Fetch-side branch predictor: direct-mapped 2-bit counter table with a
// tagged target per entry, one-cycle registered lookup, and an update port
// from execute that also drives branch / mispredict performance counters.
//
// Handshake: both ports are valid-only. A lookup is accepted whenever
// req_valid_i is high at a rising edge and an update whenever upd_valid_i is
// high; there is no ready and no backpressure, so either may fire every cycle.
module rv_branch_predictor
    import rv_branch_predictor_pkg::*;
#(
    parameter int ENTRIES = 16,
    parameter int IDX_W   = 4,
    parameter int TAG_W   = 8
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            req_valid_i,
    input  logic [PC_W-1:0] req_pc_i,
    input  logic            flush_i,
    output logic            pred_valid_o,
    output logic            pred_taken_o,
    output logic [PC_W-1:0] pred_target_o,
    input  logic            upd_valid_i,
    input  logic [PC_W-1:0] upd_pc_i,
    input  logic            upd_taken_i,
    input  logic [PC_W-1:0] upd_target_i,
    input  logic            upd_pred_i,
    output logic [31:0]     perf_branches_o,
    output logic [31:0]     perf_mispred_o
);

    logic            valid_q  [ENTRIES];
    logic [TAG_W-1:0] tag_q   [ENTRIES];
    logic [PC_W-1:0] target_q [ENTRIES];
    bht_ctr_t        ctr_q    [ENTRIES];

    logic            pred_valid_q, pred_valid_d;
    logic            pred_taken_q, pred_taken_d;
    logic [PC_W-1:0] pred_target_q, pred_target_d;
    logic [31:0]     branches_q, mispred_q;

    logic [IDX_W-1:0] req_idx, upd_idx;
    logic [TAG_W-1:0] req_tag, upd_tag;
    logic             req_hit, upd_hit;
    logic             upd_hit_we, upd_alloc;
    bht_ctr_t         upd_ctr_next;

    // PC bits outside index/tag (and the byte offset) do not take part.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{req_pc_i[PC_W-1:IDX_W+TAG_W+2], req_pc_i[1:0],
                              upd_pc_i[PC_W-1:IDX_W+TAG_W+2], upd_pc_i[1:0]};

    assign req_idx = req_pc_i[IDX_W+1:2];
    assign req_tag = req_pc_i[IDX_W+TAG_W+1:IDX_W+2];
    assign upd_idx = upd_pc_i[IDX_W+1:2];
    assign upd_tag = upd_pc_i[IDX_W+TAG_W+1:IDX_W+2];

    assign req_hit = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

    assign upd_hit_we = upd_valid_i & upd_hit;
    assign upd_alloc  = upd_valid_i & ~upd_hit & upd_taken_i;

    rv_bht_counter u_bht_counter (
        .ctr_i   (ctr_q[upd_idx]),
        .taken_i (upd_taken_i),
        .ctr_o   (upd_ctr_next)
    );

    // Lookup reads current table state, so a same-cycle update is not bypassed.
    always_comb begin
        pred_valid_d  = req_valid_i & ~flush_i;
        pred_taken_d  = pred_valid_d & req_hit & ctr_q[req_idx][1];
        pred_target_d = pred_taken_d ? target_q[req_idx] : '0;
    end

    // Register the prediction; reset drops any pending result at once.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pred_valid_q  <= 1'b0;
            pred_taken_q  <= 1'b0;
            pred_target_q <= '0;
        end else begin
            pred_valid_q  <= pred_valid_d;
            pred_taken_q  <= pred_taken_d;
            pred_target_q <= pred_target_d;
        end
    end

    // Table write: train on a hit, allocate on a taken miss, ignore not-taken misses.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= BHT_RST;
            end
        end else begin
            for (int i = 0; i < ENTRIES; i++) begin
                if (upd_idx == IDX_W'(i)) begin
                    if (upd_hit_we) begin
                        ctr_q[i] <= upd_ctr_next;
                        if (upd_taken_i) target_q[i] <= upd_target_i;
                    end else if (upd_alloc) begin
                        valid_q[i]  <= 1'b1;
                        tag_q[i]    <= upd_tag;
                        target_q[i] <= upd_target_i;
                        ctr_q[i]    <= BHT_ALLOC;
                    end
                end
            end
        end
    end

    // Performance counters, free-running and wrapping.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            branches_q <= '0;
            mispred_q  <= '0;
        end else if (upd_valid_i) begin
            branches_q <= branches_q + 32'd1;
            if (upd_pred_i != upd_taken_i) mispred_q <= mispred_q + 32'd1;
        end
    end

    assign pred_valid_o    = pred_valid_q;
    assign pred_taken_o    = pred_taken_q;
    assign pred_target_o   = pred_target_q;
    assign perf_branches_o = branches_q;
    assign perf_mispred_o  = mispred_q;

endmodule

// File: tb/tb_rv_branch_predictor.sv
// Bench for rv_branch_predictor: directed scenarios plus a randomized run,
// all checked against a behavioural table model kept here.
module tb_rv_branch_predictor;

  localparam int ENTRIES = 16;
  localparam int IDX_W   = 4;
  localparam int TAG_W   = 8;

  // ---------------- clock / reset ----------------
  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        req_valid_i = 1'b0;
  logic [63:0] req_pc_i = '0;
  logic        flush_i = 1'b0;
  logic        pred_valid_o;
  logic        pred_taken_o;
  logic [63:0] pred_target_o;
  logic        upd_valid_i = 1'b0;
  logic [63:0] upd_pc_i = '0;
  logic        upd_taken_i = 1'b0;
  logic [63:0] upd_target_i = '0;
  logic        upd_pred_i = 1'b0;
  logic [31:0] perf_branches_o;
  logic [31:0] perf_mispred_o;

  always #5 clk_i = ~clk_i;

  rv_branch_predictor #(.ENTRIES(ENTRIES), .IDX_W(IDX_W), .TAG_W(TAG_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_pc_i(req_pc_i), .flush_i(flush_i),
    .pred_valid_o(pred_valid_o), .pred_taken_o(pred_taken_o), .pred_target_o(pred_target_o),
    .upd_valid_i(upd_valid_i), .upd_pc_i(upd_pc_i), .upd_taken_i(upd_taken_i),
    .upd_target_i(upd_target_i), .upd_pred_i(upd_pred_i),
    .perf_branches_o(perf_branches_o), .perf_mispred_o(perf_mispred_o)
  );

  // ---------------- reference model + scoreboard ----------------
  int          total = 0;
  int          bad   = 0;
  bit          m_valid  [ENTRIES];
  int unsigned m_tag    [ENTRIES];
  logic [63:0] m_target [ENTRIES];
  int          m_ctr    [ENTRIES];   // 0..3, 2 and above means taken
  logic [31:0] exp_br;
  logic [31:0] exp_mis;
  logic [65:0] exp_q[$];             // {valid, taken, target}
  logic [65:0] got;
  logic [65:0] exp;

  function automatic int unsigned pc_idx(input logic [63:0] pc);
    return int'((pc / 4) % ENTRIES);
  endfunction

  function automatic int unsigned pc_tag(input logic [63:0] pc);
    return int'((pc / (4 * ENTRIES)) % (1 << TAG_W));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 1'b0; m_tag[i] = 0; m_target[i] = '0; m_ctr[i] = 1;
    end
    exp_br = '0; exp_mis = '0;
    exp_q.delete();
  endtask

  // ---------------- driver tasks ----------------
  // One cycle: predict from the model state before this edge, then train it.
  task automatic drive(input logic req, input logic flush, input logic [63:0] pc,
                       input logic upd, input logic [63:0] upc, input logic utaken,
                       input logic [63:0] utgt, input logic upred);
    int unsigned ri, ui;
    bit          hit, pv, pt;
    ri  = pc_idx(pc);
    hit = m_valid[ri] && (m_tag[ri] == pc_tag(pc));
    pv  = req && !flush;
    pt  = pv && hit && (m_ctr[ri] >= 2);
    exp_q.push_back({pv, pt, pt ? m_target[ri] : 64'd0});
    if (upd) begin
      exp_br = exp_br + 1;
      if (upred != utaken) exp_mis = exp_mis + 1;
      ui = pc_idx(upc);
      if (m_valid[ui] && m_tag[ui] == pc_tag(upc)) begin
        if (utaken) begin
          m_ctr[ui] = (m_ctr[ui] == 3) ? 3 : m_ctr[ui] + 1;
          m_target[ui] = utgt;
        end else begin
          m_ctr[ui] = (m_ctr[ui] == 0) ? 0 : m_ctr[ui] - 1;
        end
      end else if (utaken) begin
        m_valid[ui] = 1'b1; m_tag[ui] = pc_tag(upc); m_target[ui] = utgt; m_ctr[ui] = 2;
      end
    end
    req_valid_i = req; flush_i = flush; req_pc_i = pc;
    upd_valid_i = upd; upd_pc_i = upc; upd_taken_i = utaken;
    upd_target_i = utgt; upd_pred_i = upred;
    @(posedge clk_i); #1;
  endtask

  task automatic lookup(input logic [63:0] pc);
    drive(1'b1, 1'b0, pc, 1'b0, 64'd0, 1'b0, 64'd0, 1'b0);
  endtask

  task automatic update(input logic [63:0] pc, input logic taken,
                        input logic [63:0] tgt, input logic pred);
    drive(1'b0, 1'b0, 64'd0, 1'b1, pc, taken, tgt, pred);
  endtask

  task automatic do_reset();
    req_valid_i = 0; flush_i = 0; upd_valid_i = 0; upd_taken_i = 0; upd_pred_i = 0;
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    @(posedge clk_i); #1;
    model_reset();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    total++; if (pred_valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", pred_valid_o); end
    total++; if (pred_taken_o !== 1'b0) begin bad++; $display("FAIL reset_taken got=%b exp=0", pred_taken_o); end
    total++; if (pred_target_o !== 64'd0) begin bad++; $display("FAIL reset_target got=%h exp=0", pred_target_o); end
    total++; if (perf_branches_o !== 32'd0 || perf_mispred_o !== 32'd0) begin
      bad++; $display("FAIL reset_perf got=%0d/%0d exp=0/0", perf_branches_o, perf_mispred_o);
    end
  endtask

  task automatic test_lookup_miss();
    lookup(64'h1000);
    got = {pred_valid_o, pred_taken_o, pred_target_o}; exp = exp_q.pop_front();
    total++; if (got !== exp) begin bad++; $display("FAIL miss_pred got=%h exp=%h", got, exp); end
    total++; if (got !== {1'b1, 1'b0, 64'd0}) begin bad++; $display("FAIL miss_literal got=%h exp=%h", got, {1'b1, 1'b0, 64'd0}); end
  endtask

  task automatic test_allocate();
    update(64'h1000, 1'b1, 64'h2000, 1'b0);
    void'(exp_q.pop_front());
    lookup(64'h1000);
    got = {pred_valid_o, pred_taken_o, pred_target_o}; exp = exp_q.pop_front();
    total++; if (got !== exp) begin bad++; $display("FAIL alloc_pred got=%h exp=%h", got, exp); end
    total++; if (pred_taken_o !== 1'b1 || pred_target_o !== 64'h2000) begin
      bad++; $display("FAIL alloc_literal got=%b/%h exp=1/2000", pred_taken_o, pred_target_o);
    end
    total++; if (perf_branches_o !== 32'd1 || perf_mispred_o !== 32'd1) begin
      bad++; $display("FAIL alloc_perf got=%0d/%0d exp=1/1", perf_branches_o, perf_mispred_o);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) update(64'h1000, 1'b1, 64'h2000, 1'b1);
    update(64'h1000, 1'b0, 64'h0, 1'b1);
    lookup(64'h1000);
    for (int i = 0; i < 5; i++) void'(exp_q.pop_front());
    got = {pred_valid_o, pred_taken_o, pred_target_o}; exp = exp_q.pop_front();
    total++; if (got !== exp || pred_taken_o !== 1'b1) begin bad++; $display("FAIL sat_one_nt got=%h exp=%h", got, exp); end
    update(64'h1000, 1'b0, 64'h0, 1'b1);
    lookup(64'h1000);
    void'(exp_q.pop_front());
    got = {pred_valid_o, pred_taken_o, pred_target_o}; exp = exp_q.pop_front();
    total++; if (got !== exp || pred_taken_o !== 1'b0) begin bad++; $display("FAIL sat_two_nt got=%h exp=%h", got, exp); end
    total++; if (perf_branches_o !== exp_br || perf_mispred_o !== exp_mis) begin
      bad++; $display("FAIL sat_perf got=%0d/%0d exp=%0d/%0d", perf_branches_o, perf_mispred_o, exp_br, exp_mis);
    end
  endtask

  task automatic test_alias();
    update(64'h1000, 1'b1, 64'h2000, 1'b0);
    update(64'h1040, 1'b1, 64'h3000, 1'b0);
    lookup(64'h1000);
    for (int i = 0; i < 2; i++) void'(exp_q.pop_front());
    got = {pred_valid_o, pred_taken_o, pred_target_o}; exp = exp_q.pop_front();
    total++; if (got !== exp || pred_taken_o !== 1'b0) begin bad++; $display("FAIL alias_old got=%h exp=%h", got, exp); end
    update(64'h5000, 1'b0, 64'h7777, 1'b0);
    lookup(64'h1040);
    void'(exp_q.pop_front());
    got = {pred_valid_o, pred_taken_o, pred_target_o}; exp = exp_q.pop_front();
    total++; if (got !== exp || pred_target_o !== 64'h3000) begin bad++; $display("FAIL alias_new got=%h exp=%h", got, exp); end
  endtask

  task automatic test_same_cycle_and_flush();
    do_reset();
    drive(1'b1, 1'b0, 64'h1000, 1'b1, 64'h1000, 1'b1, 64'h2000, 1'b0);
    got = {pred_valid_o, pred_taken_o, pred_target_o}; exp = exp_q.pop_front();
    total++; if (got !== exp || pred_taken_o !== 1'b0) begin bad++; $display("FAIL rbw_pred got=%h exp=%h", got, exp); end
    lookup(64'h1000);
    got = {pred_valid_o, pred_taken_o, pred_target_o}; exp = exp_q.pop_front();
    total++; if (got !== exp || pred_taken_o !== 1'b1) begin bad++; $display("FAIL rbw_next got=%h exp=%h", got, exp); end
    drive(1'b1, 1'b1, 64'h1000, 1'b0, 64'd0, 1'b0, 64'd0, 1'b0);
    got = {pred_valid_o, pred_taken_o, pred_target_o}; exp = exp_q.pop_front();
    total++; if (got !== exp || pred_valid_o !== 1'b0) begin bad++; $display("FAIL flush_pred got=%h exp=%h", got, exp); end
    drive(1'b0, 1'b0, 64'h1000, 1'b0, 64'd0, 1'b0, 64'd0, 1'b0);
    got = {pred_valid_o, pred_taken_o, pred_target_o}; exp = exp_q.pop_front();
    total++; if (got !== exp) begin bad++; $display("FAIL idle_pred got=%h exp=%h", got, exp); end
  endtask

  task automatic test_random();
    logic [63:0] pc, upc;
    for (int n = 0; n < 400; n++) begin
      pc  = 64'h1000 + 64'($urandom_range(0, 3) << 6) + 64'($urandom_range(0, 3) << 2) + 64'($urandom_range(0, 3));
      upc = 64'h1000 + 64'($urandom_range(0, 3) << 6) + 64'($urandom_range(0, 3) << 2) + 64'($urandom_range(0, 3));
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 7) == 0), pc,
            1'($urandom_range(0, 2) != 0), upc, 1'($urandom_range(0, 1)),
            {$urandom, $urandom}, 1'($urandom_range(0, 1)));
      got = {pred_valid_o, pred_taken_o, pred_target_o}; exp = exp_q.pop_front();
      total++; if (got !== exp) begin bad++; $display("FAIL rand_pred n=%0d got=%h exp=%h", n, got, exp); end
      total++; if (perf_branches_o !== exp_br || perf_mispred_o !== exp_mis) begin
        bad++; $display("FAIL rand_perf n=%0d got=%0d/%0d exp=%0d/%0d", n, perf_branches_o, perf_mispred_o, exp_br, exp_mis);
      end
    end
  endtask

  task automatic test_async_reset();
    update(64'h1000, 1'b1, 64'h2000, 1'b0);
    update(64'h1000, 1'b1, 64'h2000, 1'b0);
    lookup(64'h1000);
    for (int i = 0; i < 2; i++) void'(exp_q.pop_front());
    got = {pred_valid_o, pred_taken_o, pred_target_o}; exp = exp_q.pop_front();
    total++; if (got !== exp || pred_taken_o !== 1'b1) begin bad++; $display("FAIL arst_pre got=%h exp=%h", got, exp); end
    req_valid_i = 1'b0; upd_valid_i = 1'b0;
    #2 rst_i = 1'b1;
    #1;
    total++; if ({pred_valid_o, pred_taken_o, pred_target_o} !== 66'd0) begin
      bad++; $display("FAIL arst_pred got=%b/%b/%h exp=0/0/0", pred_valid_o, pred_taken_o, pred_target_o);
    end
    total++; if (perf_branches_o !== 32'd0 || perf_mispred_o !== 32'd0) begin
      bad++; $display("FAIL arst_perf got=%0d/%0d exp=0/0", perf_branches_o, perf_mispred_o);
    end
    @(negedge clk_i); rst_i = 1'b0;
    model_reset();
    @(posedge clk_i); #1;
    lookup(64'h1000);
    got = {pred_valid_o, pred_taken_o, pred_target_o}; exp = exp_q.pop_front();
    total++; if (got !== exp || got !== {1'b1, 1'b0, 64'd0}) begin bad++; $display("FAIL arst_after got=%h exp=%h", got, exp); end
  endtask

  // ---------------- sequence + final report ----------------
  initial begin
    model_reset();
    test_reset();
    test_lookup_miss();
    test_allocate();
    test_back_to_back();
    test_alias();
    test_same_cycle_and_flush();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
